// File: rtl/lpc_dec.sv
// LPC synthesis: 10th-order all-pole filter driven by a pitch impulse train or LFSR noise.
// One output sample per accepted strobe. The computation takes 13 clocks: EXC, then 10 MAC cycles, then OUT.
module lpc_dec #(
  parameter int COEF_FRAC   = 13,
  parameter int PULSE_AMP   = 8192,
  parameter int NOISE_SHIFT = 2,
  parameter int ACC_W       = 40
)(
  input  logic               clk,
  input  logic               rst,
  input  logic signed [15:0] A0,
  input  logic signed [15:0] A1,
  input  logic signed [15:0] A2,
  input  logic signed [15:0] A3,
  input  logic signed [15:0] A4,
  input  logic signed [15:0] A5,
  input  logic signed [15:0] A6,
  input  logic signed [15:0] A7,
  input  logic signed [15:0] A8,
  input  logic signed [15:0] A9,
  input  logic signed [15:0] A10,
  input  logic               voiced,
  input  logic [15:0]        freq_count,
  input  logic               load,
  input  logic               v,
  output logic signed [15:0] y,
  output logic               vout,
  output logic               busy,
  output logic               overrun
);

  typedef enum logic [1:0] {IDLE, EXC, MAC, OUT} state_t;

  localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(32767);
  localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(-32768);

  state_t state, state_nxt;

  logic signed [15:0] a_in [0:10];
  logic signed [15:0] a_sh [0:10];
  logic signed [15:0] a_pd [0:10];
  logic               vc_sh, vc_pd, pend;
  logic [15:0]        per_sh, per_pd;
  logic [15:0]        pcnt, cnt_nxt;
  logic [15:0]        lfsr, lfsr_nxt;
  logic signed [15:0] hist [0:9];
  logic [3:0]         kidx;
  logic signed [ACC_W-1:0] acc, acc_sh, prod_x;
  logic signed [15:0] e, ma, mb, ysat;
  logic signed [31:0] prod;

  always_comb begin
    a_in[0] = A0; a_in[1] = A1; a_in[2] = A2; a_in[3] = A3;
    a_in[4] = A4; a_in[5] = A5; a_in[6] = A6; a_in[7] = A7;
    a_in[8] = A8; a_in[9] = A9; a_in[10] = A10;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (v) state_nxt = EXC;
      EXC:     state_nxt = MAC;
      MAC:     if (kidx == 4'd9) state_nxt = OUT;
      OUT:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // The pitch counter is not touched by load, so pitch phase is continuous across frames.
  always_comb begin
    e        = '0;
    cnt_nxt  = pcnt;
    lfsr_nxt = lfsr;
    if (vc_sh) begin
      if (per_sh == 16'd0) begin
        cnt_nxt = '0;
      end else if (pcnt == 16'd0) begin
        e       = 16'(PULSE_AMP);
        cnt_nxt = per_sh - 16'd1;
      end else begin
        cnt_nxt = pcnt - 16'd1;
      end
    end else begin
      e        = $signed(lfsr) >>> NOISE_SHIFT;
      lfsr_nxt = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      cnt_nxt  = '0;
    end
  end

  // A single multiplier serves both the gain product (EXC) and the predictor taps (MAC).
  always_comb begin
    ma     = (state == EXC) ? e     : a_sh[kidx + 4'd1];
    mb     = (state == EXC) ? a_sh[0] : hist[kidx];
    prod   = 32'(ma) * 32'(mb);
    prod_x = {{(ACC_W-32){prod[31]}}, prod};
    acc_sh = acc >>> COEF_FRAC;
    if (acc_sh > SAT_HI)      ysat = 16'sh7FFF;
    else if (acc_sh < SAT_LO) ysat = 16'sh8000;
    else                      ysat = acc_sh[15:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 11; i++) begin
        a_sh[i] <= '0;
        a_pd[i] <= '0;
      end
      for (int i = 0; i < 10; i++) hist[i] <= '0;
      vc_sh   <= 1'b0;
      vc_pd   <= 1'b0;
      per_sh  <= '0;
      per_pd  <= '0;
      pend    <= 1'b0;
      pcnt    <= '0;
      lfsr    <= 16'hACE1;
      acc     <= '0;
      kidx    <= '0;
      y       <= '0;
      vout    <= 1'b0;
      overrun <= 1'b0;
    end else begin
      vout    <= 1'b0;
      overrun <= v && (state != IDLE);
      if (state == IDLE) begin
        if (load) begin
          for (int i = 0; i < 11; i++) a_sh[i] <= a_in[i];
          vc_sh  <= voiced;
          per_sh <= freq_count;
        end
      end else begin
        if (load) begin
          for (int i = 0; i < 11; i++) a_pd[i] <= a_in[i];
          vc_pd  <= voiced;
          per_pd <= freq_count;
          pend   <= 1'b1;
        end
        // A load arriving on the OUT edge itself is the newest value and goes straight in.
        if (state == OUT && (load || pend)) begin
          for (int i = 0; i < 11; i++) a_sh[i] <= load ? a_in[i] : a_pd[i];
          vc_sh  <= load ? voiced : vc_pd;
          per_sh <= load ? freq_count : per_pd;
          pend   <= 1'b0;
        end
      end
      case (state)
        EXC: begin
          acc  <= prod_x;
          pcnt <= cnt_nxt;
          lfsr <= lfsr_nxt;
          kidx <= '0;
        end
        MAC: begin
          acc  <= acc - prod_x;
          kidx <= kidx + 4'd1;
        end
        OUT: begin
          y    <= ysat;
          vout <= 1'b1;
          for (int i = 9; i > 0; i--) hist[i] <= hist[i-1];
          hist[0] <= ysat;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lpc_dec.sv
// Bench for lpc_dec: directed vector table, reset/handshake sequences, and random traffic
// compared against a sample-level reference model.
module tb_lpc_dec;

  localparam int PULSE = 8192;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic signed [15:0] a [0:10];
  logic               voiced = 1'b0;
  logic [15:0]        freq_count = '0;
  logic               load = 1'b0;
  logic               v = 1'b0;
  logic signed [15:0] y;
  logic               vout, busy, overrun;

  always #5 clk = ~clk;

  lpc_dec dut (
    .clk(clk), .rst(rst),
    .A0(a[0]), .A1(a[1]), .A2(a[2]), .A3(a[3]), .A4(a[4]), .A5(a[5]),
    .A6(a[6]), .A7(a[7]), .A8(a[8]), .A9(a[9]), .A10(a[10]),
    .voiced(voiced), .freq_count(freq_count), .load(load), .v(v),
    .y(y), .vout(vout), .busy(busy), .overrun(overrun)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // ---------------- reference model (one call = one whole sample) ----------------
  int          m_a [0:10];
  int          p_a [0:10];
  bit          m_vc, p_vc, pend;
  int          m_per, p_per, m_cnt;
  logic [15:0] m_lfsr;
  int          m_h [0:9];

  function automatic int model_sample();
    int     e, sv;
    longint acc, s;
    if (m_vc) begin
      if (m_per == 0) begin e = 0; m_cnt = 0; end
      else if (m_cnt == 0) begin e = PULSE; m_cnt = m_per - 1; end
      else begin e = 0; m_cnt = m_cnt - 1; end
    end else begin
      sv     = $signed(m_lfsr);
      e      = sv >>> 2;
      m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
      m_cnt  = 0;
    end
    acc = longint'(e) * m_a[0];
    for (int k = 1; k <= 10; k++) acc = acc - longint'(m_a[k]) * m_h[k-1];
    s = acc >>> 13;
    if (s > 32767)  s = 32767;
    if (s < -32768) s = -32768;
    for (int i = 9; i > 0; i--) m_h[i] = m_h[i-1];
    m_h[0] = int'(s);
    return int'(s);
  endfunction

  // ---------------- cycle engine: drives st_* and checks every cycle ----------------
  logic signed [15:0] st_a [0:10];
  bit                 st_vc, st_ld, st_v;
  logic [15:0]        st_per;
  int cyc, last_acc, vout_at, exp_y_next, cur_y, obs_ovr, obs_vout;
  bit ovr_next;

  function automatic void model_reset();
    for (int i = 0; i < 11; i++) begin m_a[i] = 0; p_a[i] = 0; end
    for (int i = 0; i < 10; i++) m_h[i] = 0;
    m_vc = 0; p_vc = 0; pend = 0; m_per = 0; p_per = 0; m_cnt = 0;
    m_lfsr = 16'hACE1;
    cyc = 0; last_acc = -100; vout_at = -1; exp_y_next = 0; cur_y = 0;
    ovr_next = 0; obs_ovr = 0; obs_vout = 0;
  endfunction

  task automatic eng_cycle();
    bit idle, ev;
    ev = (cyc == vout_at);
    if (ev) cur_y = exp_y_next;
    chk("vout", int'(vout), int'(ev));
    chk("y", int'(y), cur_y);
    chk("busy", int'(busy), int'(cyc >= last_acc + 1 && cyc <= last_acc + 12));
    chk("overrun", int'(overrun), int'(ovr_next));
    if (overrun) obs_ovr++;
    if (vout) obs_vout++;
    ovr_next = 0;
    load = st_ld;
    v    = st_v;
    if (st_ld) begin
      for (int i = 0; i < 11; i++) a[i] = st_a[i];
      voiced = st_vc;
      freq_count = st_per;
    end
    idle = (cyc >= last_acc + 13);
    if (st_ld) begin
      if (idle) begin
        for (int i = 0; i < 11; i++) m_a[i] = st_a[i];
        m_vc = st_vc; m_per = st_per;
      end else begin
        for (int i = 0; i < 11; i++) p_a[i] = st_a[i];
        p_vc = st_vc; p_per = st_per; pend = 1;
      end
    end
    if (cyc == last_acc + 12 && pend) begin
      for (int i = 0; i < 11; i++) m_a[i] = p_a[i];
      m_vc = p_vc; m_per = p_per; pend = 0;
    end
    if (st_v) begin
      if (idle) begin
        last_acc   = cyc;
        vout_at    = cyc + 13;
        exp_y_next = model_sample();
      end else ovr_next = 1;
    end
    @(negedge clk);
    cyc++;
    load = 1'b0;
    v    = 1'b0;
  endtask

  // ---------------- directed helpers ----------------
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; load = 1'b0; v = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    model_reset();
  endtask

  task automatic do_load(input int a0, input int a1, input bit vc, input int per);
    load = 1'b1;
    for (int i = 0; i < 11; i++) a[i] = '0;
    a[0] = 16'(a0); a[1] = 16'(a1);
    voiced = vc; freq_count = 16'(per);
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic do_sample(output int yv, output int lat);
    v = 1'b1; lat = -1; yv = 0;
    for (int i = 1; i <= 20 && lat < 0; i++) begin
      @(negedge clk);
      v = 1'b0;
      if (vout) begin lat = i; yv = int'(y); end
    end
    if (lat < 0) chk("vout_timeout", 0, 1);
    repeat (3) @(negedge clk);
  endtask

  typedef struct {
    string nm;
    bit    do_rst;
    bit    do_ld;
    int    a0, a1;
    bit    vc;
    int    per;
    int    exp_y;
  } vec_t;

  vec_t tbl [$];
  int   yv, lat, cnt;

  initial begin
    for (int i = 0; i < 11; i++) a[i] = '0;
    tbl = '{
      '{"pulse0", 1, 1, 8192, 0, 1, 4, 8192}, '{"pulse1", 0, 0, 0, 0, 0, 0, 0},
      '{"pulse2", 0, 0, 0, 0, 0, 0, 0},       '{"pulse3", 0, 0, 0, 0, 0, 0, 0},
      '{"pulse4", 0, 0, 0, 0, 0, 0, 8192},    '{"pulse5", 0, 0, 0, 0, 0, 0, 0},
      '{"pulse6", 0, 0, 0, 0, 0, 0, 0},       '{"pulse7", 0, 0, 0, 0, 0, 0, 0},
      '{"pulse8", 0, 0, 0, 0, 0, 0, 8192},
      '{"decay0", 1, 1, 8192, -4096, 1, 100, 8192}, '{"decay1", 0, 0, 0, 0, 0, 0, 4096},
      '{"decay2", 0, 0, 0, 0, 0, 0, 2048},    '{"decay3", 0, 0, 0, 0, 0, 0, 1024},
      '{"decay4", 0, 0, 0, 0, 0, 0, 512},
      '{"sat0", 1, 1, 8192, -16384, 1, 100, 8192}, '{"sat1", 0, 0, 0, 0, 0, 0, 16384},
      '{"sat2", 0, 0, 0, 0, 0, 0, 32767},     '{"sat3", 0, 0, 0, 0, 0, 0, 32767},
      '{"sat4", 0, 0, 0, 0, 0, 0, 32767},
      '{"noise0", 1, 1, 8192, 0, 0, 0, -5320}, '{"noise1", 0, 0, 0, 0, 0, 0, 5744}
    };

    // table-driven directed vectors
    foreach (tbl[i]) begin
      if (tbl[i].do_rst) do_reset();
      if (tbl[i].do_ld) do_load(tbl[i].a0, tbl[i].a1, tbl[i].vc, tbl[i].per);
      do_sample(yv, lat);
      chk({tbl[i].nm, "_y"}, yv, tbl[i].exp_y);
      chk({tbl[i].nm, "_lat"}, lat, 13);
    end

    // reset in the middle of MAC aborts the sample
    v = 1'b1;
    @(negedge clk); v = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_y", int'(y), 0);
    chk("rst_vout", int'(vout), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_overrun", int'(overrun), 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    cnt = 0;
    repeat (20) begin @(negedge clk); if (vout) cnt++; end
    chk("rst_stray_vout", cnt, 0);
    do_sample(yv, lat);
    chk("rst_lat", lat, 13);
    chk("rst_sample_y", yv, 0);

    // handshake: overrun 5 clocks in, load during MAC deferred to next sample
    do_reset();
    for (int i = 0; i < 11; i++) st_a[i] = '0;
    for (int n = 0; n < 62; n++) begin
      st_ld = (n == 0 || n == 8);
      st_v  = (n == 1 || n == 6 || n == 20 || n == 34 || n == 48);
      if (n == 0) begin st_a[0] = 16'sd8192; st_a[1] = -16'sd4096; st_vc = 1; st_per = 16'd100; end
      if (n == 8) begin st_a[0] = 16'sd4096; st_a[1] = -16'sd2048; st_vc = 1; st_per = 16'd2; end
      eng_cycle();
      if (n == 14) chk("hs_first_y_old_coefs", int'(y), 8192);
      if (n == 19) begin
        chk("hs_overrun_count", obs_ovr, 1);
        chk("hs_vout_count", obs_vout, 1);
      end
    end

    // random traffic against the model
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      st_ld = ($urandom_range(0, 24) == 0);
      st_v  = ($urandom_range(0, 7) == 0);
      if (st_ld) begin
        st_a[0] = 16'(int'($urandom_range(0, 16384)) - 8192);
        for (int i = 1; i < 11; i++) st_a[i] = 16'(int'($urandom_range(0, 3000)) - 1500);
        st_vc  = ($urandom_range(0, 2) != 0);
        st_per = 16'($urandom_range(0, 6));
      end
      eng_cycle();
    end
    st_ld = 0; st_v = 0;
    repeat (16) eng_cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
